// File: rtl/svi_rr_arbiter.sv
// rtl/svi_rr_arbiter.sv - round-robin arbiter with registered one-hot grant and burst cap
module svi_rr_arbiter #(
  parameter int SIZE      = 8,
  parameter int MAX_BURST = 4,
  localparam int IDX_W    = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic [SIZE-1:0]  i_req,
  output logic [SIZE-1:0]  o_gnt,
  output logic             o_gnt_valid,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic [7:0]       o_burst_cnt
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
  localparam logic [7:0] BURST_CAP = 8'(MAX_BURST);

  logic [0:0]       state, n_state;
  logic [IDX_W-1:0] ptr, n_ptr;
  logic [IDX_W-1:0] n_idx;
  logic [7:0]       n_cnt;
  logic [SIZE-1:0]  n_gnt;
  logic [SIZE-1:0]  others;
  logic [IDX_W-1:0] owner_next;
  logic             owner_req;
  logic             cap_hit;
  logic [7:0]       cnt_inc;

  function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(SIZE - 1)) ? '0 : i + 1'b1;
  endfunction

  // Scan descending distance so the smallest distance from start is written last.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [SIZE-1:0] vec,
                                               input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] pick;
    int j;
    pick = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      j = int'(start) + i;
      if (j >= SIZE) j = j - SIZE;
      if (vec[j[IDX_W-1:0]]) pick = j[IDX_W-1:0];
    end
    return pick;
  endfunction

  always_comb begin
    owner_req  = i_req[o_gnt_idx];
    others     = i_req & ~o_gnt;
    owner_next = inc_idx(o_gnt_idx);
    cap_hit    = (MAX_BURST != 0) && (o_burst_cnt >= BURST_CAP);
    cnt_inc    = (o_burst_cnt == 8'hFF) ? o_burst_cnt : o_burst_cnt + 8'd1;

    n_state = state;
    n_ptr   = ptr;
    n_idx   = o_gnt_idx;
    n_cnt   = o_burst_cnt;

    case (state)
      ST_IDLE: begin
        if (|i_req) begin
          n_state = ST_GRANT;
          n_idx   = rr_pick(i_req, ptr);
          n_cnt   = 8'd1;
        end
      end
      ST_GRANT: begin
        if (!owner_req || (cap_hit && |others)) begin
          // Release and forced rotation hand over at the same edge, no bubble.
          n_ptr = owner_next;
          if (|others) begin
            n_idx = rr_pick(others, owner_next);
            n_cnt = 8'd1;
          end else begin
            n_state = ST_IDLE;
            n_idx   = '0;
            n_cnt   = 8'd0;
          end
        end else if (!(|others)) begin
          n_cnt = cap_hit ? o_burst_cnt : cnt_inc;
        end else begin
          n_cnt = cnt_inc;
        end
      end
      default: begin
        n_state = ST_IDLE;
        n_idx   = '0;
        n_cnt   = 8'd0;
      end
    endcase

    n_gnt = (n_state == ST_GRANT) ? (SIZE'(1) << n_idx) : '0;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      o_gnt       <= '0;
      o_gnt_valid <= 1'b0;
      o_gnt_idx   <= '0;
      o_burst_cnt <= 8'd0;
    end else begin
      state       <= n_state;
      ptr         <= n_ptr;
      o_gnt       <= n_gnt;
      o_gnt_valid <= (n_state == ST_GRANT);
      o_gnt_idx   <= n_idx;
      o_burst_cnt <= n_cnt;
    end
  end

endmodule

// File: tb/tb_svi_rr_arbiter.sv
// tb/tb_svi_rr_arbiter.sv - self-checking bench for svi_rr_arbiter
module tb_svi_rr_arbiter;

  localparam int SIZE = 8;
  localparam int MAXB = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [7:0] burst_cnt;

  int checks;
  int errors;

  // Reference model: owner (-1 = none), scan pointer, burst count.
  int m_owner;
  int m_ptr;
  int m_cnt;

  svi_rr_arbiter #(.SIZE(SIZE), .MAX_BURST(MAXB)) dut (
    .i_clk       (clk),
    .i_arst_n    (rst_n),
    .i_req       (req),
    .o_gnt       (gnt),
    .o_gnt_valid (gnt_valid),
    .o_gnt_idx   (gnt_idx),
    .o_burst_cnt (burst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
  endtask

  function automatic int first_from(input logic [7:0] r, input int start);
    for (int d = 0; d < SIZE; d++) begin
      if (r[3'((start + d) % SIZE)]) return (start + d) % SIZE;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [7:0] r);
    logic [7:0] others;
    if (m_owner < 0) begin
      m_owner = first_from(r, m_ptr);
      m_cnt   = (m_owner < 0) ? 0 : 1;
    end else begin
      others = r & ~(8'd1 << m_owner);
      if (!r[3'(m_owner)] || (m_cnt == MAXB && others != 0)) begin
        m_ptr   = (m_owner + 1) % SIZE;
        m_owner = first_from(others, m_ptr);
        m_cnt   = (m_owner < 0) ? 0 : 1;
      end else begin
        m_cnt = (m_cnt + 1 > MAXB) ? MAXB : m_cnt + 1;
      end
    end
  endtask

  task automatic tick(input logic [7:0] r);
    req = r;
    @(posedge clk);
    if (rst_n) model_step(r);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    tick(8'hFF);
    tick(8'hFF);
    checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt: got %h want 00", gnt); end
    checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", gnt_valid); end
    checks++; if (gnt_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", gnt_idx); end
    checks++; if (burst_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", burst_cnt); end
    rst_n = 1'b1;
    tick(8'hFF);
    checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL reset_release_gnt: got %h want 01", gnt); end
    checks++; if (gnt_valid !== 1'b1) begin errors++; $display("FAIL reset_release_valid: got %b want 1", gnt_valid); end
    checks++; if (burst_cnt !== 8'd1) begin errors++; $display("FAIL reset_release_cnt: got %0d want 1", burst_cnt); end
  endtask

  task automatic test_single_lane();
    int exp_cnt;
    do_reset();
    for (int c = 1; c <= 10; c++) begin
      tick(8'h04);
      exp_cnt = (c > MAXB) ? MAXB : c;
      checks++; if (gnt !== 8'h04) begin errors++; $display("FAIL single_gnt c=%0d: got %h want 04", c, gnt); end
      checks++; if (gnt_idx !== 3'd2) begin errors++; $display("FAIL single_idx c=%0d: got %0d want 2", c, gnt_idx); end
      checks++; if (burst_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL single_cnt c=%0d: got %0d want %0d", c, burst_cnt, exp_cnt); end
    end
    tick(8'h00);
    checks++; if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin errors++; $display("FAIL single_idle: got gnt=%h valid=%b want 00/0", gnt, gnt_valid); end
    checks++; if (burst_cnt !== 8'd0) begin errors++; $display("FAIL single_idle_cnt: got %0d want 0", burst_cnt); end
    tick(8'hFF);
    checks++; if (gnt !== 8'h08) begin errors++; $display("FAIL single_ptr_scan: got %h want 08", gnt); end
  endtask

  task automatic test_burst_cap();
    logic [7:0] exp_g;
    int exp_cnt;
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      tick(8'h81);
      exp_g   = (((c - 1) / MAXB) % 2 == 0) ? 8'h01 : 8'h80;
      exp_cnt = (c - 1) % MAXB + 1;
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL burst_gnt c=%0d: got %h want %h", c, gnt, exp_g); end
      checks++; if (burst_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL burst_cnt c=%0d: got %0d want %0d", c, burst_cnt, exp_cnt); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] reqs [7];
    logic [7:0] exps [7];
    reqs = '{8'h0E, 8'h0E, 8'h0C, 8'h0C, 8'h08, 8'h08, 8'h00};
    exps = '{8'h02, 8'h02, 8'h04, 8'h04, 8'h08, 8'h08, 8'h00};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      tick(reqs[c]);
      checks++; if (gnt !== exps[c]) begin errors++; $display("FAIL b2b_gnt c=%0d: got %h want %h", c, gnt, exps[c]); end
      checks++; if (gnt_valid !== (exps[c] != 8'h00)) begin errors++; $display("FAIL b2b_valid c=%0d: got %b", c, gnt_valid); end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    tick(8'h04);
    tick(8'h00);
    for (int c = 0; c < 3; c++) tick(8'h20);
    checks++; if (gnt !== 8'h20 || burst_cnt !== 8'd3) begin errors++; $display("FAIL mid_pre: got gnt=%h cnt=%0d want 20/3", gnt, burst_cnt); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0 || burst_cnt !== 8'd0) begin
      errors++; $display("FAIL mid_async_clear: got gnt=%h valid=%b idx=%0d cnt=%0d want all 0", gnt, gnt_valid, gnt_idx, burst_cnt);
    end
    #1 rst_n = 1'b1;
    model_reset();
    tick(8'h20);
    checks++; if (gnt !== 8'h20 || burst_cnt !== 8'd1) begin errors++; $display("FAIL mid_regrant: got gnt=%h cnt=%0d want 20/1", gnt, burst_cnt); end
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    tick(8'h24);
    checks++; if (gnt !== 8'h04) begin errors++; $display("FAIL mid_ptr_zero: got %h want 04", gnt); end
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic [7:0] exp_g;
    int wait_cnt [SIZE];
    do_reset();
    r = 8'h00;
    for (int i = 0; i < SIZE; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      r = r ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      tick(r);
      exp_g = (m_owner < 0) ? 8'h00 : (8'd1 << m_owner);
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rand_gnt c=%0d: got %h want %h", c, gnt, exp_g); end
      checks++; if (burst_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL rand_cnt c=%0d: got %0d want %0d", c, burst_cnt, m_cnt); end
      checks++; if (gnt_idx !== ((m_owner < 0) ? 3'd0 : 3'(m_owner))) begin errors++; $display("FAIL rand_idx c=%0d: got %0d want %0d", c, gnt_idx, m_owner); end
      checks++; if (!$onehot0(gnt) || gnt_valid !== (|gnt)) begin errors++; $display("FAIL rand_onehot_valid c=%0d: gnt=%h valid=%b", c, gnt, gnt_valid); end
      checks++; if (gnt_valid && gnt !== (8'd1 << gnt_idx)) begin errors++; $display("FAIL rand_idx_match c=%0d: gnt=%h idx=%0d", c, gnt, gnt_idx); end
      checks++; if ((gnt & ~r) != 8'h00) begin errors++; $display("FAIL rand_gnt_no_req c=%0d: gnt=%h req=%h", c, gnt, r); end
      for (int i = 0; i < SIZE; i++) begin
        if (r[i] && !gnt[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > (SIZE - 1) * MAXB + 1) begin
          errors++; $display("FAIL rand_wait lane=%0d c=%0d: waited %0d want <=%0d", i, c, wait_cnt[i], (SIZE - 1) * MAXB + 1);
          wait_cnt[i] = 0;
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    req    = 8'h00;
    model_reset();
    test_reset();
    test_single_lane();
    test_burst_cap();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
